bsg_vanilla_remote_load_wb_queue: RTL and testbench
===================================================

// Module: bsg_vanilla_remote_load_wb_queue
// PURPOSE
//  Buffers remote load responses (remote_load_resp_s) coming from the network endpoint, formats them, and presents them
//  one at a time to the int/FP regfile writeback arbiter. Sits between the endpoint return path and the WB stage.
//  Formatting covers byte/hex lane extraction and zero/sign extension.
//  Provides an occupancy count and empty flag so fences can wait for outstanding loads to drain.
// PARAMETERS
//  els_p            4   queue depth in entries; >=2, need not be a power of 2
//  starve_limit_p   8   blocked-head cycles before force_wb_o asserts (used only with the guard macro); >=1
// PORTS
//  clk_i          in   1    clock
//  reset_i        in   1    synchronous, active-high reset
//  v_i            in   1    incoming response valid
//  data_i         in   43   remote_load_resp_s {float_wb, reg_id[4:0], is_unsigned_op, is_byte_op, is_hex_op, part_sel[1:0], data[31:0]}
//  ready_o        out  1    queue can accept; a transfer happens when v_i & ready_o
//  wb_v_o         out  1    head entry valid
//  wb_float_o     out  1    head targets FP regfile (float_wb)
//  wb_reg_id_o    out  5    destination register
//  wb_data_o      out  32   formatted writeback data
//  wb_yumi_i      in   1    arbiter consumes head this cycle; legal only when wb_v_o=1
//  count_o        out  $clog2(els_p+1)  entries held
//  empty_o        out  1    count_o==0
//  force_wb_o     out  1    request core to yield WB port (0 when guard compiled out)
// BEHAVIOUR
//  - Reset: rd/wr pointers=0, count_o=0, empty_o=1, ready_o=1, wb_v_o=0, force_wb_o=0, starvation counter=0.
//    Any entries held are discarded, including entries present when reset is asserted.
//  - Storage holds the raw 43-bit response. Formatting is combinational from the head entry.
//  - Latency: an entry enqueued in cycle t appears on wb_v_o in cycle t+1. There is no same-cycle bypass.
//  - ready_o = (count < els_p). It depends only on state, not on wb_yumi_i.
//    When full, a simultaneous dequeue does not allow an enqueue that cycle.
//  - Pointers increment modulo els_p: at els_p-1 they wrap to 0.
//  - Count update: enq&~deq: +1; deq&~enq: -1; both: unchanged.
//  - wb_yumi_i while wb_v_o=0 is illegal; assert in simulation.
//  - Formatting, d=data, ps=part_sel, s=~is_unsigned_op:
//    byte: b=d[8*ps+:8];  out={{24{s&b[7]}},b}
//    hex:  h=d[16*ps[1]+:16];  out={{16{s&h[15]}},h}
//    else (word): out=d; ps is ignored
//    is_byte_op and is_hex_op both set is illegal; assert in simulation.
//  - Entries drain strictly in FIFO order. The int and FP destinations share the single head.
// CONFIGURATION
//  VANILLA_RLOAD_STARVE_GUARD_EN defined:
//  - The counter increments each cycle that wb_v_o=1 and wb_yumi_i=0. It saturates at starve_limit_p.
//  - The counter clears to 0 on wb_yumi_i or when the queue is empty.
//  - force_wb_o = (counter==starve_limit_p). It drops the cycle after yumi.
//  VANILLA_RLOAD_STARVE_GUARD_EN not defined:
//  - No counter is built. force_wb_o is tied to 0.
// TESTING
//  1 Word load: data=0xDEADBEEF, reg_id=5, float_wb=0, enq at t
//    -> t+1: wb_v_o=1, wb_data_o=0xDEADBEEF, wb_reg_id_o=5, wb_float_o=0.
//  2 Byte sign extension: data=0x80FF7F01, byte, ps=3, signed -> 0xFFFFFF80.
//    Same with ps=2 -> 0xFFFFFFFF; ps=1 -> 0x0000007F.
//    Hex, ps=2, unsigned -> 0x000080FF.
//  3 Fill/full: els_p=4, 4 enqueues with yumi held 0 -> count_o=4, ready_o=0.
//    v_i held high -> no overwrite; subsequent dequeues return entries 0..3 in order.
//  4 Wrap and simultaneous: steady enq+deq for 10 cycles -> count_o stays constant; FIFO order is kept across pointer wrap.
//  5 Reset mid-operation: 3 entries held, reset_i=1 for one cycle
//    -> next cycle count_o=0, empty_o=1, wb_v_o=0, ready_o=1.
//  6 Guard: macro defined, starve_limit_p=8, head blocked 8 cycles -> force_wb_o=1 in cycle 9.
//    Yumi -> force_wb_o=0 the next cycle. With the macro undefined, force_wb_o stays 0.

Source files
------------

// File: rtl/bsg_vanilla_remote_load_wb_queue.sv
// rtl/bsg_vanilla_remote_load_wb_queue.sv - FIFO of remote load responses feeding the regfile writeback arbiter
// Optional starvation guard built only when VANILLA_RLOAD_STARVE_GUARD_EN is defined.
module bsg_vanilla_remote_load_wb_queue #(
    parameter int els_p          = 4,
    parameter int starve_limit_p = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         v_i,
    input  logic [42:0]                  data_i,
    output logic                         ready_o,
    output logic                         wb_v_o,
    output logic                         wb_float_o,
    output logic [4:0]                   wb_reg_id_o,
    output logic [31:0]                  wb_data_o,
    input  logic                         wb_yumi_i,
    output logic [$clog2(els_p+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         force_wb_o
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    logic [42:0]      mem [els_p];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;
    logic             enq;
    logic             deq;

    assign ready_o = (count < cnt_w'(els_p));
    assign wb_v_o  = (count != '0);
    assign empty_o = (count == '0);
    assign count_o = count;
    assign enq     = v_i & ready_o;
    assign deq     = wb_yumi_i & wb_v_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)
                wr_ptr <= (wr_ptr == ptr_w'(els_p - 1)) ? '0 : wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= (rd_ptr == ptr_w'(els_p - 1)) ? '0 : rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: validity is tracked entirely by count.
    always_ff @(posedge clk_i) begin
        if (enq)
            mem[wr_ptr] <= data_i;
    end

    logic [42:0] head;
    logic        head_unsigned;
    logic        head_byte;
    logic        head_hex;
    logic [1:0]  head_ps;
    logic [31:0] head_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign head          = mem[rd_ptr];
    assign wb_float_o    = head[42];
    assign wb_reg_id_o   = head[41:37];
    assign head_unsigned = head[36];
    assign head_byte     = head[35];
    assign head_hex      = head[34];
    assign head_ps       = head[33:32];
    assign head_data     = head[31:0];

    always_comb begin
        lane_b    = head_data[8*head_ps +: 8];
        lane_h    = head_ps[1] ? head_data[31:16] : head_data[15:0];
        wb_data_o = head_data;
        if (head_byte)
            wb_data_o = {{24{~head_unsigned & lane_b[7]}}, lane_b};
        else if (head_hex)
            wb_data_o = {{16{~head_unsigned & lane_h[15]}}, lane_h};
    end

`ifdef VANILLA_RLOAD_STARVE_GUARD_EN
    localparam int starve_w = $clog2(starve_limit_p + 1);

    logic [starve_w-1:0] starve_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i || wb_yumi_i || empty_o)
            starve_cnt <= '0;
        else if (wb_v_o && (starve_cnt != starve_w'(starve_limit_p)))
            starve_cnt <= starve_cnt + starve_w'(1);
    end

    assign force_wb_o = (starve_cnt == starve_w'(starve_limit_p));
`else
    assign force_wb_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(wb_yumi_i && !wb_v_o));
            assert (!(wb_v_o && head_byte && head_hex));
        end
    end

endmodule

// File: tb/tb_bsg_vanilla_remote_load_wb_queue.sv
// tb/tb_bsg_vanilla_remote_load_wb_queue.sv - directed scoreboard bench for the remote load writeback queue
module tb_bsg_vanilla_remote_load_wb_queue;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic [42:0] data_i;
    logic        ready_o;
    logic        wb_v_o;
    logic        wb_float_o;
    logic [4:0]  wb_reg_id_o;
    logic [31:0] wb_data_o;
    logic        wb_yumi_i;
    logic [2:0]  count_o;
    logic        empty_o;
    logic        force_wb_o;

    int checks = 0;
    int errors = 0;
    logic [37:0] sb [$];

    bsg_vanilla_remote_load_wb_queue #(.els_p(4), .starve_limit_p(8)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .wb_v_o      (wb_v_o),
        .wb_float_o  (wb_float_o),
        .wb_reg_id_o (wb_reg_id_o),
        .wb_data_o   (wb_data_o),
        .wb_yumi_i   (wb_yumi_i),
        .count_o     (count_o),
        .empty_o     (empty_o),
        .force_wb_o  (force_wb_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [42:0] mk(input logic fl, input logic [4:0] rid, input logic uns,
                                       input logic by, input logic hx, input logic [1:0] ps,
                                       input logic [31:0] d);
        return {fl, rid, uns, by, hx, ps, d};
    endfunction

    function automatic logic [31:0] fmt(input logic [42:0] p);
        logic [7:0]  b;
        logic [15:0] h;
        logic        sgn;
        sgn = ~p[36];
        b   = 8'(p[31:0] >> (8 * p[33:32]));
        h   = 16'(p[31:0] >> (16 * p[33]));
        if (p[35])
            return sgn ? 32'($signed(b)) : {24'd0, b};
        else if (p[34])
            return sgn ? 32'($signed(h)) : {16'd0, h};
        return p[31:0];
    endfunction

    // One clock cycle; inputs are driven and outputs sampled 1 time unit after posedge.
    task automatic step(input logic v, input logic [42:0] d, input logic y);
        logic        fire_in;
        logic [37:0] exp;
        fire_in = v && (sb.size() < 4);
        chk("ready", ready_o, sb.size() < 4);
        if (y && sb.size() != 0) begin
            exp = sb.pop_front();
            chk("head_float", wb_float_o, exp[37]);
            chk("head_reg",   wb_reg_id_o, exp[36:32]);
            chk("head_data",  wb_data_o, exp[31:0]);
        end
        v_i       = v;
        data_i    = d;
        wb_yumi_i = y;
        @(posedge clk);
        #1;
        v_i       = 1'b0;
        wb_yumi_i = 1'b0;
        if (fire_in)
            sb.push_back({d[42:37], fmt(d)});
        chk("count", count_o, sb.size());
        chk("empty", empty_o, sb.size() == 0);
        chk("wb_v",  wb_v_o, sb.size() != 0);
    endtask

    initial begin
        reset_i   = 1'b1;
        v_i       = 1'b0;
        data_i    = '0;
        wb_yumi_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_ready", ready_o, 1);
        chk("rst_wb_v",  wb_v_o, 0);
        chk("rst_force", force_wb_o, 0);

        // Word load appears the cycle after enqueue
        step(1, mk(0, 5, 0, 0, 0, 2'd3, 32'hDEADBEEF), 0);
        chk("t1_v",     wb_v_o, 1);
        chk("t1_data",  wb_data_o, 32'hDEADBEEF);
        chk("t1_reg",   wb_reg_id_o, 5);
        chk("t1_float", wb_float_o, 0);
        step(0, '0, 1);

        // Byte / hex extraction and extension
        step(1, mk(1, 7, 0, 1, 0, 2'd3, 32'h80FF7F01), 0);
        chk("byte_ps3", wb_data_o, 32'hFFFFFF80);
        step(0, '0, 1);
        step(1, mk(0, 8, 0, 1, 0, 2'd2, 32'h80FF7F01), 0);
        chk("byte_ps2", wb_data_o, 32'hFFFFFFFF);
        step(0, '0, 1);
        step(1, mk(0, 9, 0, 1, 0, 2'd1, 32'h80FF7F01), 0);
        chk("byte_ps1", wb_data_o, 32'h0000007F);
        step(0, '0, 1);
        step(1, mk(1, 10, 1, 0, 1, 2'd2, 32'h80FF7F01), 0);
        chk("hex_ps2_u", wb_data_o, 32'h000080FF);
        step(0, '0, 1);
        step(1, mk(0, 11, 0, 0, 1, 2'd0, 32'h12348765), 0);
        step(1, mk(0, 12, 1, 1, 0, 2'd0, 32'h123487F5), 1);
        step(0, '0, 1);

        // Fill to full, push while full, then drain in order
        for (int i = 0; i < 4; i++)
            step(1, mk(i[0], 5'(i + 1), 1, 0, 0, 2'd0, 32'hA000_0000 + i), 0);
        chk("full_count", count_o, 4);
        chk("full_ready", ready_o, 0);
        step(1, mk(1, 31, 1, 0, 0, 2'd0, 32'hBAD0BAD0), 0);
        step(1, mk(1, 30, 1, 0, 0, 2'd0, 32'hBAD1BAD1), 1);
        for (int i = 0; i < 3; i++)
            step(0, '0, 1);
        chk("drained", empty_o, 1);

        // Steady enqueue+dequeue across pointer wrap
        step(1, mk(0, 1, 0, 0, 0, 2'd0, 32'h0000_1111), 0);
        step(1, mk(1, 2, 0, 0, 0, 2'd0, 32'h0000_2222), 0);
        for (int i = 0; i < 10; i++) begin
            step(1, mk(i[1], 5'(i + 3), 0, 1, 0, 2'(i), 32'hC3A5_9681 + 32'(i) * 32'h0101_0101), 1);
            chk("steady_count", count_o, 2);
        end
        step(0, '0, 1);
        step(0, '0, 1);

        // Reset with entries held
        for (int i = 0; i < 3; i++)
            step(1, mk(0, 5'(i), 0, 0, 0, 2'd0, 32'h5555_0000 + i), 0);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        sb.delete();
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_empty", empty_o, 1);
        chk("mid_rst_wb_v",  wb_v_o, 0);
        chk("mid_rst_ready", ready_o, 1);

        // Starvation guard
        step(1, mk(0, 4, 0, 0, 0, 2'd0, 32'h0BAD_F00D), 0);
        for (int k = 1; k <= 8; k++) begin
            step(0, '0, 0);
`ifdef VANILLA_RLOAD_STARVE_GUARD_EN
            chk("force_blocked", force_wb_o, k == 8);
`else
            chk("force_off", force_wb_o, 0);
`endif
        end
        step(0, '0, 1);
        chk("force_after_yumi", force_wb_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
